// File: rtl/m_uart_pwm_mc_pkg.sv
// Shared definitions for the multi-channel UART command decoder / PWM block:
// frame header bytes, body length, error codes, parser states and the
// packed layout of the 11-byte frame body (CH, period, high, times).
package m_uart_pwm_mc_pkg;

  localparam logic [7:0]  HDR0           = 8'hAA;
  localparam logic [7:0]  HDR1           = 8'h55;
  localparam int unsigned FRAME_BODY_LEN = 11;
  localparam int unsigned BODY_W         = FRAME_BODY_LEN * 8;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CS   = 2'd1,
    ERR_ARG  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_BODY,
    ST_CHECK
  } parse_state_e;

  // Body bytes in arrival order; the first byte (CH) ends up in the MSBs.
  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] period;
    logic [31:0] high;
    logic [15:0] times;
  } frame_body_t;

endpackage

// File: rtl/m_uart_pwm_mc_if.sv
// Byte stream from the serial-to-parallel receiver.
//   i_rx_en   : one-cycle strobe, i_rx_data valid
//   i_rx_data : received byte
interface m_uart_pwm_mc_if;

  logic       i_rx_en;
  logic [7:0] i_rx_data;

  modport master (output i_rx_en, output i_rx_data);
  modport slave  (input  i_rx_en, input  i_rx_data);

endinterface

// File: rtl/m_uart_pwm_mc_pwm_ch.sv
// Single PWM channel.
//   clk, rst_n   : clock, synchronous active-low reset
//   load_i       : load period/high/times this cycle (N==0 stops the channel)
//   period_i     : period in cycles
//   high_i       : high time in cycles (>= period gives constant high)
//   times_i      : number of periods to generate
//   pwm_o        : registered PWM output
//   busy_o       : registered, high while periods remain
module m_pwm_ch #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMES_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   high_i,
  input  logic [TIMES_W-1:0] times_i,
  output logic               pwm_o,
  output logic               busy_o
);

  logic               busy_q,  busy_d;
  logic               pwm_q,   pwm_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   per_q,   per_d;
  logic [CNT_W-1:0]   high_q,  high_d;
  logic [TIMES_W-1:0] rem_q,   rem_d;
  logic [CNT_W-1:0]   phase_inc;

  assign phase_inc = phase_q + CNT_W'(1);

  // Next state: a load always wins over the natural end of the last period.
  always_comb begin
    busy_d  = busy_q;
    pwm_d   = pwm_q;
    phase_d = phase_q;
    per_d   = per_q;
    high_d  = high_q;
    rem_d   = rem_q;
    if (load_i) begin
      per_d   = period_i;
      high_d  = high_i;
      rem_d   = times_i;
      phase_d = '0;
      busy_d  = (times_i != '0);
      pwm_d   = (times_i != '0) && (high_i != '0);
    end else if (busy_q) begin
      if (phase_q == per_q - CNT_W'(1)) begin
        phase_d = '0;
        rem_d   = rem_q - TIMES_W'(1);
        if (rem_q == TIMES_W'(1)) begin
          busy_d = 1'b0;
          pwm_d  = 1'b0;
        end else begin
          pwm_d  = (high_q != '0);
        end
      end else begin
        phase_d = phase_inc;
        pwm_d   = (phase_inc < high_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      pwm_q   <= 1'b0;
      phase_q <= '0;
      per_q   <= '0;
      high_q  <= '0;
      rem_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      high_q  <= high_d;
      rem_q   <= rem_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/m_uart_pwm_mc.sv
// Multi-channel UART command decoder driving NUM_CH PWM channels.
// Parses 13-byte frames AA 55 CH P[4] H[4] N[2] CS (CS = XOR of CH..N0),
// with inter-byte timeout, and loads the addressed channel on success.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   rx_if          : received byte stream (i_rx_en / i_rx_data)
//   o_pwm, o_busy  : per-channel PWM output and busy flag
//   o_frame_ok     : one-cycle pulse, frame accepted and applied
//   o_frame_err    : one-cycle pulse, frame rejected
//   o_err_code     : cause of last error, held until the next error
module m_uart_pwm_mc
  import m_uart_pwm_mc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMES_W     = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  m_uart_pwm_mc_if.slave    rx_if,
  output logic [NUM_CH-1:0] o_pwm,
  output logic [NUM_CH-1:0] o_busy,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IDX_W = 4;

  parse_state_e       state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [BODY_W-1:0]  body_q,  body_d;
  logic [7:0]         cs_q,    cs_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;
  logic               ok_q,    ok_d;
  logic               err_q,   err_d;
  err_code_e          code_q,  code_d;

  frame_body_t        fb;
  logic [CNT_W-1:0]   per_w;
  logic [CNT_W-1:0]   high_w;
  logic [TIMES_W-1:0] times_w;
  logic               arg_bad_c;
  logic               rx_en;
  logic [7:0]         rx_data;

  assign rx_en   = rx_if.i_rx_en;
  assign rx_data = rx_if.i_rx_data;

  // Field view of the staged body; only the low CNT_W/TIMES_W bits are used.
  assign fb        = body_q;
  assign per_w     = CNT_W'(fb.period);
  assign high_w    = CNT_W'(fb.high);
  assign times_w   = TIMES_W'(fb.times);
  assign arg_bad_c = (32'(fb.ch) >= NUM_CH) || ((per_w == '0) && (times_w != '0));

  // Parser next state, checksum, timeout and frame result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    body_d  = body_q;
    cs_d    = cs_q;
    tmo_d   = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_en && (rx_data == HDR0)) state_d = ST_HDR2;
      end
      ST_HDR2: begin
        if (rx_en) begin
          if (rx_data == HDR1) begin
            state_d = ST_BODY;
            idx_d   = '0;
            cs_d    = '0;
          end else if (rx_data != HDR0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BODY: begin
        if (rx_en) begin
          body_d = {body_q[BODY_W-9:0], rx_data};
          cs_d   = cs_q ^ rx_data;
          if (idx_q == IDX_W'(FRAME_BODY_LEN - 1)) state_d = ST_CHECK;
          else                                      idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_CHECK: begin
        if (rx_en) begin
          state_d = ST_IDLE;
          if (rx_data != cs_q) begin
            err_d  = 1'b1;
            code_d = ERR_CS;
          end else if (arg_bad_c) begin
            err_d  = 1'b1;
            code_d = ERR_ARG;
          end else begin
            ok_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Idle-cycle watchdog while a frame is in progress.
    if ((state_q != ST_IDLE) && !rx_en) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
      end else begin
        tmo_d   = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      body_q  <= '0;
      cs_q    <= '0;
      tmo_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      body_q  <= body_d;
      cs_q    <= cs_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;

  // The ok pulse doubles as the load strobe; the body is still staged then.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load_c;
    assign load_c = ok_q && (fb.ch == 8'(g));
    m_pwm_ch #(
      .CNT_W   (CNT_W),
      .TIMES_W (TIMES_W)
    ) u_ch (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .load_i   (load_c),
      .period_i (per_w),
      .high_i   (high_w),
      .times_i  (times_w),
      .pwm_o    (o_pwm[g]),
      .busy_o   (o_busy[g])
    );
  end

endmodule

// File: doc/m_uart_pwm_mc.md
Name: m_uart_pwm_mc

Overview:
Multi-channel successor to the single-channel UART command decoder plus PWM LED pair. It consumes bytes from the existing serial-to-parallel receiver (i_rx_en/i_rx_data) and parses fixed-length, checksummed command frames. It also handles an inter-byte timeout and error reporting, and drives NUM_CH independent PWM channels, each with period, high time and repeat count. It sits between m_s2p and the board LED/PWM pins.

Parameters:
NUM_CH, 4, number of PWM channels (1..255)
CNT_W, 32, width of period/high counters
TIMES_W, 16, width of repeat counter
TIMEOUT_CYC, 200000, idle cycles between frame bytes before abort (1 ms at 200 MHz)

Ports:
i_clk  in  1  system clock, 200 MHz
i_rst_n  in  1  synchronous active-low reset
i_rx_en  in  1  one-cycle strobe, i_rx_data valid
i_rx_data  in  8  received byte
o_pwm  out  NUM_CH  per-channel PWM output
o_busy  out  NUM_CH  channel currently generating pulses
o_frame_ok  out  1  one-cycle pulse, frame accepted and applied
o_frame_err  out  1  one-cycle pulse, frame rejected
o_err_code  out  2  cause of last error: 1 checksum, 2 bad channel/period, 3 timeout; holds until next error

Behaviour:
- Reset is synchronous and active-low on i_clk. It is sampled only at the clock edge, with no asynchronous path. All outputs reset to 0, the parser goes to IDLE, all channels go idle.
- Frame layout, 13 bytes: 0xAA, 0x55, CH, P3..P0 (period, big-endian), H3..H0 (high, big-endian), N1..N0 (times, big-endian), CS.
- Checksum: CS = XOR of CH through N0. The header bytes are excluded.
- Only the low CNT_W/TIMES_W bits of the fields are used. Upper bytes are ignored when the parameters are narrower.
- Parser FSM states: IDLE, HDR2, BODY (byte index 0..10), CHECK.
  - IDLE: on 0xAA go to HDR2. Other bytes are ignored.
  - HDR2: on 0x55 go to BODY. On 0xAA stay in HDR2. On any other byte go to IDLE.
  - BODY: shift bytes into staging registers. After N0 go to CHECK.
  - CHECK: consumes the next byte (CS) and issues the frame result in the same cycle it exits.
- Frame result:
  - o_frame_ok is asserted exactly 1 cycle after the i_rx_en that carries CS.
  - o_frame_err (code 1) is asserted instead when CS mismatches.
  - o_frame_err (code 2) is asserted instead when CH >= NUM_CH, or when P == 0 with N != 0.
  - On every result the parser returns to IDLE.
- Timeout:
  - In HDR2/BODY/CHECK a counter counts cycles without i_rx_en and clears on each i_rx_en.
  - On reaching TIMEOUT_CYC: pulse o_frame_err with code 3 and go to IDLE.
  - No timeout in IDLE.
- Apply: in the o_frame_ok cycle, channel CH loads P, H, N. The other channels are unaffected.
  - N == 0: stop command. o_pwm[CH] and o_busy[CH] are 0 from the next cycle.
  - N > 0: the channel restarts immediately, even mid-pulse. The first PWM cycle begins the cycle after load.
- PWM channel:
  - Phase counter runs 0..P-1. o_pwm is 1 while phase < H, so H >= P gives constant high and H == 0 gives constant low.
  - At phase == P-1, the repeat count decrements.
  - After N complete periods, o_pwm is 0 and o_busy is 0 in the following cycle.
  - o_busy is 1 from the cycle after load until completion.
- Simultaneous events:
  - An i_rx_en in the same cycle as a frame result is processed by the IDLE state. A new 0xAA is therefore not lost.
  - A channel reaching its end in the load cycle: the load wins.
- Reset mid-frame or mid-PWM aborts everything. No partial frame survives.

Decomposition:
- Shared package holds:
  - header constants HDR0 = 0xAA, HDR1 = 0x55
  - FRAME_BODY_LEN = 11
  - err code constants ERR_NONE/ERR_CS/ERR_ARG/ERR_TMO
  - parser state enum
- One natural sub-module: m_pwm_ch, a single channel with load/period/high/times inputs and pwm/busy outputs, instantiated NUM_CH times via generate.
- Parser, checksum and timeout stay in the top level.

Test Plan:
- Valid frame AA 55 01 00000008 00000003 0002 CS=0x08^0x03^0x01^0x02=0x08 -> o_frame_ok 1 cycle after CS. o_pwm[1] gives 3 high/5 low twice, then o_busy[1]=0 after 16 cycles. Other channels stay 0.
- Same frame with CS=0x09 -> o_frame_err, o_err_code=1, no o_pwm activity.
- CH=0x04 with NUM_CH=4 -> o_frame_err, code 2. P=0, N=1 -> code 2.
- Stop bytes after the 5th byte for more than TIMEOUT_CYC (bench TIMEOUT_CYC=100) -> o_frame_err code 3 at cycle 100. A following complete valid frame is accepted.
- Channel 0 running P=10, H=10, N=1000. Load ch0 with N=0 -> o_pwm[0]=0, o_busy[0]=0 the cycle after o_frame_ok. Reload P=4, H=1, N=1 mid-pulse -> restarts with 1 high/3 low.
- Stream AA AA 55 + valid frame -> accepted. Assert i_rst_n=0 for one cycle mid-frame -> all outputs 0, parser in IDLE, remaining bytes ignored until the next 0xAA 0x55.
